uart_tx_sched: RTL and testbench

- Shares the single UART transmitter between the two memory-stage store lanes (lane 1 = older instruction, lane 2 = younger).
- Buffers bytes in a FIFO that preserves program order.
- Drains the FIFO to the UART one byte at a time, honouring the UART's ready signal and a minimum inter-byte gap.
- Asserts a stall to the pipeline before the FIFO can overflow.
- Sits between the M-stage UART address decode and the uart instance.

---
 rtl/uart_tx_sched.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between the two M-stage store
// lanes. Bytes are queued in program order (lane 1 before lane 2) and drained
// one at a time. The drain honours uart_ready and keeps a minimum idle gap
// between write strobes.
// Optional feature: define UART_TX_SCHED_CRLF_EN to expand each 0x0A into the
// pair 0x0D, 0x0A on the wire.
module uart_tx_sched #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int GAP   = 2
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             wr1,
    input  logic [7:0]       dat1,
    input  logic             wr2,
    input  logic [7:0]       dat2,
    output logic             stall,
    input  logic             uart_ready,
    output logic             uart_wr,
    output logic [7:0]       uart_dat,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    // Gap counter holds GAP-1 down to 0 and is at least one bit wide.
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) + 1 : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

`ifdef UART_TX_SCHED_CRLF_EN
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_ISSUE_LF} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  w_wr_ptr2;
    logic [PTR_W:0]    r_count;
    logic [GAP_W-1:0]  r_gap;
    logic              r_overflow;
    logic              w_pop;
    logic              w_strobe;
    logic [7:0]        w_strobe_dat;
    logic [7:0]        w_head;
    logic              w_pending;
    logic [PTR_W:0]    w_free;
    logic              w_acc1;
    logic              w_acc2;
    logic              w_drop;
    logic [1:0]        w_pushes;
`ifdef UART_TX_SCHED_CRLF_EN
    logic              r_lf;
`endif

    assign w_head    = r_mem[r_rd_ptr];
    assign w_pending = (r_count != '0) && uart_ready;

    // Free space counts the slot released by a pop in this same cycle, so a
    // full FIFO that is draining can still accept one byte.
    assign w_free    = (PTR_W+1)'(DEPTH) - r_count + {{PTR_W{1'b0}}, w_pop};
    assign w_acc1    = wr1 && (w_free != '0);
    assign w_acc2    = wr2 && (w_free > {{PTR_W{1'b0}}, w_acc1});
    assign w_drop    = (wr1 && !w_acc1) || (wr2 && !w_acc2);
    assign w_pushes  = {1'b0, w_acc1} + {1'b0, w_acc2};
    assign w_wr_ptr2 = r_wr_ptr + PTR_W'(1);

    // Two slots stay in reserve for the store pair already in the M stage.
    assign stall     = (r_count >= (PTR_W+1)'(DEPTH - 2));
    assign count     = r_count;
    assign overflow  = r_overflow;

    // Drain FSM state register.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Drain FSM next state, pop and strobe request. HOLD hands over straight
    // to ISSUE when more work is waiting, so back-to-back strobes land
    // exactly GAP+1 cycles apart.
    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_strobe     = 1'b0;
        w_strobe_dat = w_head;
        case (r_state)
            S_IDLE: begin
                if (w_pending) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_strobe = 1'b1;
`ifdef UART_TX_SCHED_CRLF_EN
                if (w_head == 8'h0A) begin
                    // Send CR first; the LF stays queued until ISSUE_LF.
                    w_strobe_dat = 8'h0D;
                    w_next       = (GAP > 0) ? S_HOLD : S_ISSUE_LF;
                end else begin
                    w_pop  = 1'b1;
                    w_next = (GAP > 0) ? S_HOLD : S_IDLE;
                end
`else
                w_pop  = 1'b1;
                w_next = (GAP > 0) ? S_HOLD : S_IDLE;
`endif
            end
            S_HOLD: begin
                if (r_gap == '0) begin
`ifdef UART_TX_SCHED_CRLF_EN
                    if (r_lf) begin
                        if (uart_ready) w_next = S_ISSUE_LF;
                    end else begin
                        w_next = w_pending ? S_ISSUE : S_IDLE;
                    end
`else
                    w_next = w_pending ? S_ISSUE : S_IDLE;
`endif
                end
            end
`ifdef UART_TX_SCHED_CRLF_EN
            S_ISSUE_LF: begin
                w_strobe = 1'b1;
                w_pop    = 1'b1;
                w_next   = (GAP > 0) ? S_HOLD : S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Gap counter: loaded on every strobe, counts down while holding.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)                                  r_gap <= '0;
        else if (w_strobe)                          r_gap <= GAP_LOAD;
        else if (r_state == S_HOLD && r_gap != '0)  r_gap <= r_gap - 1'b1;
    end

`ifdef UART_TX_SCHED_CRLF_EN
    // Remembers that a CR went out and its LF is still owed.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)                     r_lf <= 1'b0;
        else if (r_state == S_ISSUE)   r_lf <= !w_pop;
        else if (r_state == S_ISSUE_LF) r_lf <= 1'b0;
    end
`endif

    // Registered UART strobe; the data register keeps its last byte when idle.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
        end else begin
            uart_wr <= w_strobe;
            if (w_strobe) uart_dat <= w_strobe_dat;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_pushes);
            r_count    <= r_count + (PTR_W+1)'(w_pushes) - (PTR_W+1)'(w_pop);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // FIFO storage: lane 1 takes the lower slot when both lanes are accepted.
    always_ff @(posedge CLK) begin
        if (w_acc1) r_mem[r_wr_ptr] <= dat1;
        if (w_acc2) r_mem[w_acc1 ? w_wr_ptr2 : r_wr_ptr] <= dat2;
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: directed scenarios followed by a randomized
// run against a queue-based reference model.
module tb_uart_tx_sched;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int GAP   = 2;

    logic         CLK;
    logic         NRST;
    logic         wr1;
    logic [7:0]   dat1;
    logic         wr2;
    logic [7:0]   dat2;
    logic         stall;
    logic         uart_ready;
    logic         uart_wr;
    logic [7:0]   uart_dat;
    logic [PTR_W:0] count;
    logic         overflow;

    int checks;
    int errors;

    uart_tx_sched #(.DEPTH(DEPTH), .PTR_W(PTR_W), .GAP(GAP)) dut (
        .CLK(CLK), .NRST(NRST),
        .wr1(wr1), .dat1(dat1), .wr2(wr2), .dat2(dat2),
        .stall(stall), .uart_ready(uart_ready),
        .uart_wr(uart_wr), .uart_dat(uart_dat),
        .count(count), .overflow(overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Step until a strobe is seen; returns the number of edges taken.
    task automatic wait_strobe(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!uart_wr && n < 60);
        if (!uart_wr) chk({tag, "_timeout"}, 32'(n), 32'(0));
    endtask

    task automatic do_reset();
        NRST = 1'b0;
        wr1 = 1'b0; wr2 = 1'b0; dat1 = 8'h00; dat2 = 8'h00;
        step();
        step();
        NRST = 1'b1;
    endtask

    initial begin
        int n;
        int strobes;
        byte unsigned expq[$];
        byte unsigned q[$];
        int m_ovf;
        int cyc;
        int last;
        int free;
        int a1, a2;
        logic w1, w2;
        logic [7:0] d1, d2;

        checks = 0;
        errors = 0;
        uart_ready = 1'b1;
        do_reset();

        // Reset state
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_wr", 32'(uart_wr), 32'(0));
        chk("rst_dat", 32'(uart_dat), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_stall", 32'(stall), 32'(0));

        // Single byte latency
        wr1 = 1'b1; dat1 = 8'h41;
        step();
        wr1 = 1'b0;
        chk("t1_count_push", 32'(count), 32'(1));
        chk("t1_wr_n1", 32'(uart_wr), 32'(0));
        step();
        chk("t1_wr_n1b", 32'(uart_wr), 32'(0));
        step();
        chk("t1_wr_n2", 32'(uart_wr), 32'(1));
        chk("t1_dat", 32'(uart_dat), 32'h41);
        chk("t1_count0", 32'(count), 32'(0));
        step();
        chk("t1_single", 32'(uart_wr), 32'(0));
        chk("t1_dat_hold", 32'(uart_dat), 32'h41);
        repeat (5) step();

        // Dual-lane push, order and spacing
        wr1 = 1'b1; dat1 = 8'h48; wr2 = 1'b1; dat2 = 8'h69;
        step();
        wr1 = 1'b0; wr2 = 1'b0;
        chk("t2_count", 32'(count), 32'(2));
        wait_strobe("t2_s1", n);
        chk("t2_lat", 32'(n), 32'(2));
        chk("t2_dat1", 32'(uart_dat), 32'h48);
        wait_strobe("t2_s2", n);
        chk("t2_spacing", 32'(n), 32'(GAP + 1));
        chk("t2_dat2", 32'(uart_dat), 32'h69);
        repeat (5) step();

        // Stall threshold with UART blocked
        uart_ready = 1'b0;
        strobes = 0;
        for (int i = 0; i < 14; i++) begin
            wr1 = 1'b1; dat1 = 8'(i);
            step();
            if (uart_wr) strobes++;
            chk("t3_count", 32'(count), 32'(i + 1));
            chk("t3_stall", 32'(stall), 32'((i + 1) >= DEPTH - 2));
        end
        wr1 = 1'b0;
        chk("t3_no_wr", 32'(strobes), 32'(0));
        for (int i = 0; i < 14; i++) begin
`ifdef UART_TX_SCHED_CRLF_EN
            if (i == 8'h0A) expq.push_back(8'h0D);
`endif
            expq.push_back(8'(i));
        end
        uart_ready = 1'b1;
        for (int k = 0; k < expq.size(); k++) begin
            wait_strobe("t3_drain", n);
            chk("t3_order", 32'(uart_dat), 32'(expq[k]));
            if (k == 0) begin
                chk("t3_count13", 32'(count), 32'(13));
                chk("t3_stall_drop", 32'(stall), 32'(0));
            end
        end
        step();
        chk("t3_empty", 32'(count), 32'(0));

        // Overflow with a full FIFO
        do_reset();
        uart_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr1 = 1'b1; dat1 = 8'h20 + 8'(i);
            step();
        end
        chk("t4_full", 32'(count), 32'(DEPTH));
        chk("t4_ovf_before", 32'(overflow), 32'(0));
        wr1 = 1'b1; wr2 = 1'b1; dat1 = 8'hA5; dat2 = 8'h5A;
        step();
        wr1 = 1'b0; wr2 = 1'b0;
        chk("t4_full_count", 32'(count), 32'(DEPTH));
        chk("t4_full_ovf", 32'(overflow), 32'(1));

        // Overflow with one free slot: lane 1 wins
        do_reset();
        uart_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            wr1 = 1'b1; dat1 = 8'h20 + 8'(i);
            step();
        end
        wr1 = 1'b1; wr2 = 1'b1; dat1 = 8'hA5; dat2 = 8'h5A;
        step();
        wr1 = 1'b0; wr2 = 1'b0;
        chk("t4b_count", 32'(count), 32'(DEPTH));
        chk("t4b_ovf", 32'(overflow), 32'(1));
        uart_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_strobe("t4b_drain", n);
            chk("t4b_order", 32'(uart_dat), (i == DEPTH - 1) ? 32'hA5 : 32'(8'h20 + 8'(i)));
        end
        repeat (5) step();
        chk("t4b_ovf_sticky", 32'(overflow), 32'(1));

        // Asynchronous reset during HOLD
        do_reset();
        uart_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr1 = 1'b1; dat1 = 8'h60 + 8'(i);
            step();
        end
        wr1 = 1'b0;
        uart_ready = 1'b1;
        wait_strobe("t5_s", n);
        chk("t5_count5", 32'(count), 32'(5));
        NRST = 1'b0;
        #1;
        chk("t5_async_count", 32'(count), 32'(0));
        chk("t5_async_wr", 32'(uart_wr), 32'(0));
        strobes = 0;
        repeat (3) begin
            step();
            if (uart_wr) strobes++;
        end
        NRST = 1'b1;
        repeat (20) begin
            step();
            if (uart_wr) strobes++;
        end
        chk("t5_no_strobes", 32'(strobes), 32'(0));
        chk("t5_count_after", 32'(count), 32'(0));

        // Line feed handling
        uart_ready = 1'b0;
        wr1 = 1'b1; dat1 = 8'h0A; wr2 = 1'b1; dat2 = 8'h33;
        step();
        wr1 = 1'b0; wr2 = 1'b0;
        uart_ready = 1'b1;
`ifdef UART_TX_SCHED_CRLF_EN
        wait_strobe("t6_cr", n);
        chk("t6_cr_dat", 32'(uart_dat), 32'h0D);
        chk("t6_cr_count", 32'(count), 32'(2));
        wait_strobe("t6_lf", n);
        chk("t6_lf_gap", 32'(n), 32'(GAP + 1));
        chk("t6_lf_dat", 32'(uart_dat), 32'h0A);
        chk("t6_lf_count", 32'(count), 32'(1));
`else
        wait_strobe("t6_lf", n);
        chk("t6_lf_dat", 32'(uart_dat), 32'h0A);
        chk("t6_lf_count", 32'(count), 32'(1));
`endif
        wait_strobe("t6_next", n);
        chk("t6_next_dat", 32'(uart_dat), 32'h33);
        chk("t6_count0", 32'(count), 32'(0));

        // Randomized traffic against a queue model
        do_reset();
        q.delete();
        m_ovf = 0;
        cyc = 0;
        last = -100;
        for (int t = 0; t < 1000; t++) begin
            w1 = (t < 800) && ($urandom % 3 == 0);
            w2 = (t < 800) && ($urandom % 3 == 0);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            if (d1 == 8'h0A) d1 = 8'h0B;
            if (d2 == 8'h0A) d2 = 8'h0B;
            wr1 = w1; dat1 = d1; wr2 = w2; dat2 = d2;
            uart_ready = (t >= 800) || ($urandom % 4 != 0);
            free = DEPTH - q.size();
            step();
            cyc++;
            if (uart_wr) begin
                chk("rnd_pop_nonempty", 32'(q.size() != 0), 32'(1));
                chk("rnd_spacing", 32'((cyc - last) >= GAP + 1), 32'(1));
                last = cyc;
                if (q.size() != 0) chk("rnd_dat", 32'(uart_dat), 32'(q.pop_front()));
                free++;
            end
            a1 = (w1 && free >= 1) ? 1 : 0;
            a2 = (w2 && free >= 1 + a1) ? 1 : 0;
            if ((w1 && a1 == 0) || (w2 && a2 == 0)) m_ovf = 1;
            if (a1 != 0) q.push_back(d1);
            if (a2 != 0) q.push_back(d2);
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
            chk("rnd_stall", 32'(stall), 32'(q.size() >= DEPTH - 2));
        end
        wr1 = 1'b0; wr2 = 1'b0;
        chk("rnd_drained", 32'(q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
